// File: rtl/cmp_bist_ctrl.sv
// Stimulus/response checker for the 4-bit comparator: sweeps all 256 (A, B)
// pairs, samples out1/out2 after SETTLE cycles and records pass/fail results.
module cmp_bist_ctrl #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [3:0] a_out,
   output logic [3:0] b_out,
   input  logic       dut_out1,
   input  logic       dut_out2,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [8:0] fail_count,
   output logic       first_fail_valid,
   output logic [3:0] first_fail_a,
   output logic [3:0] first_fail_b
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam logic [3:0] SETTLE_M1 = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

   state_t     state_q, state_d;
   logic [7:0] idx_q, idx_d;
   logic [3:0] a_q, a_d, b_q, b_d;
   logic [3:0] cnt_q, cnt_d;
   logic [8:0] fcnt_q, fcnt_d;
   logic       ffv_q, ffv_d;
   logic [3:0] ffa_q, ffa_d, ffb_q, ffb_d;
   logic       mismatch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= 8'd0;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         cnt_q   <= 4'd0;
         fcnt_q  <= 9'd0;
         ffv_q   <= 1'b0;
         ffa_q   <= 4'd0;
         ffb_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         ffv_q   <= ffv_d;
         ffa_q   <= ffa_d;
         ffb_q   <= ffb_d;
      end
   end

   // Expected response comes from the registered operands, which are the
   // values the comparator has been settling on since the DRIVE edge.
   assign mismatch = (dut_out1 != (a_q > b_q)) || (dut_out2 != (a_q == b_q));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      fcnt_d  = fcnt_q;
      ffv_d   = ffv_q;
      ffa_d   = ffa_q;
      ffb_d   = ffb_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               idx_d   = 8'd0;
               fcnt_d  = 9'd0;
               ffv_d   = 1'b0;
               ffa_d   = 4'd0;
               ffb_d   = 4'd0;
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            a_d     = idx_q[7:4];
            b_d     = idx_q[3:0];
            cnt_d   = 4'd0;
            state_d = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == SETTLE_M1) state_d = ST_CHECK;
            else                    cnt_d   = cnt_q + 4'd1;
         end
         ST_CHECK: begin
            if (mismatch) begin
               fcnt_d = fcnt_q + 9'd1;
               if (!ffv_q) begin
                  ffv_d = 1'b1;
                  ffa_d = a_q;
                  ffb_d = b_q;
               end
            end
            if (idx_q == 8'hFF) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = ST_DRIVE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign a_out            = a_q;
   assign b_out            = b_q;
   assign busy             = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
   assign done             = (state_q == ST_DONE);
   assign pass             = done && (fcnt_q == 9'd0);
   assign fail_count       = fcnt_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_a     = ffa_q;
   assign first_fail_b     = ffb_q;

endmodule

// File: tb/tb_cmp_bist_ctrl.sv
// Randomized bench for cmp_bist_ctrl: two instances (SETTLE=2 and SETTLE=0)
// each drive a behavioural comparator with selectable faults.
module tb_cmp_bist_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start [2];
   logic [3:0] a_o [2];
   logic [3:0] b_o [2];
   logic       o1 [2];
   logic       o2 [2];
   logic       busy [2];
   logic       done [2];
   logic       pass [2];
   logic [8:0] fcnt [2];
   logic       ffv [2];
   logic [3:0] ffa [2];
   logic [3:0] ffb [2];
   int         mode [2];
   bit         flt1 [256];
   bit         flt2 [256];
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   cmp_bist_ctrl #(.SETTLE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .a_out(a_o[0]), .b_out(b_o[0]),
      .dut_out1(o1[0]), .dut_out2(o2[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .fail_count(fcnt[0]), .first_fail_valid(ffv[0]), .first_fail_a(ffa[0]), .first_fail_b(ffb[0])
   );

   cmp_bist_ctrl #(.SETTLE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .a_out(a_o[1]), .b_out(b_o[1]),
      .dut_out1(o1[1]), .dut_out2(o2[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .fail_count(fcnt[1]), .first_fail_valid(ffv[1]), .first_fail_a(ffa[1]), .first_fail_b(ffb[1])
   );

   // Comparator under test: 0 good, 1 out2 stuck low at A=B=0xB,
   // 2 outputs swapped, 3 random per-vector bit flips from flt1/flt2.
   function automatic logic [1:0] cmp_model(input int m, input logic [3:0] a, input logic [3:0] b);
      logic [1:0] good;
      good = {a > b, a == b};
      case (m)
         1:       return {a > b, (a == b) && !(a == 4'hB && b == 4'hB)};
         2:       return {a == b, a > b};
         3:       return good ^ {flt1[{a, b}], flt2[{a, b}]};
         default: return good;
      endcase
   endfunction

   always_comb begin
      for (int d = 0; d < 2; d++) {o1[d], o2[d]} = cmp_model(mode[d], a_o[d], b_o[d]);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input int d, input string tag);
      chk({tag, "_a"}, 32'(a_o[d]), 0);
      chk({tag, "_b"}, 32'(b_o[d]), 0);
      chk({tag, "_busy"}, 32'(busy[d]), 0);
      chk({tag, "_done"}, 32'(done[d]), 0);
      chk({tag, "_pass"}, 32'(pass[d]), 0);
      chk({tag, "_fcnt"}, 32'(fcnt[d]), 0);
      chk({tag, "_ffv"}, 32'(ffv[d]), 0);
      chk({tag, "_ffab"}, {24'd0, ffa[d], ffb[d]}, 0);
   endtask

   // Run one sweep on instance d and compare against a contract-level
   // reference: every vector of the faulty model vs (A>B, A==B).
   task automatic sweep(input int d, input int m, input bit mid_start);
      int         s, per, k, exp_f, vec_err;
      bit         exp_v;
      logic [7:0] exp_ff;
      logic [1:0] r;
      s       = (d == 0) ? 2 : 0;
      per     = s + 2;
      mode[d] = m;
      exp_f   = 0;
      exp_v   = 0;
      exp_ff  = 8'h00;
      for (int v = 0; v < 256; v++) begin
         r = cmp_model(m, 4'(v >> 4), 4'(v & 15));
         if (r != {(v >> 4) > (v & 15), (v >> 4) == (v & 15)}) begin
            exp_f++;
            if (!exp_v) begin
               exp_v  = 1;
               exp_ff = 8'(v);
            end
         end
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      chk("start_done_clr", 32'(done[d]), 0);
      k = 0;
      vec_err = 0;
      while (busy[d] && k < 5000) begin
         if (k % per == per - 1 && {a_o[d], b_o[d]} != 8'(k / per)) vec_err++;
         if (mid_start && k == 100) start[d] = 1'b1;
         if (mid_start && k == 101) start[d] = 1'b0;
         k++;
         @(negedge clk);
      end
      start[d] = 1'b0;
      chk("busy_cycles", 32'(k), 32'(256 * per));
      chk("vec_order", 32'(vec_err), 0);
      chk("done", 32'(done[d]), 1);
      chk("pass", 32'(pass[d]), 32'(exp_f == 0));
      chk("fail_count", 32'(fcnt[d]), 32'(exp_f));
      chk("ff_valid", 32'(ffv[d]), 32'(exp_v));
      chk("ff_ab", {24'd0, ffa[d], ffb[d]}, {24'd0, exp_ff});
      repeat (3) @(negedge clk);
      chk("done_hold", 32'(done[d]), 1);
   endtask

   task automatic rand_faults(input int density);
      for (int v = 0; v < 256; v++) begin
         flt1[v] = ($urandom_range(0, 255) < density);
         flt2[v] = ($urandom_range(0, 255) < density);
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0;
         mode[d]  = 0;
      end
      rand_faults(0);
      #1;
      chk_reset(0, "rst2");
      chk_reset(1, "rst0");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      chk_reset(0, "idle2");
      chk_reset(1, "idle0");

      sweep(0, 0, 0);
      sweep(0, 1, 0);
      sweep(0, 2, 0);
      rand_faults(int'($urandom_range(1, 12)));
      sweep(0, 3, 0);
      sweep(1, 0, 1);
      sweep(1, 2, 0);
      rand_faults(int'($urandom_range(1, 12)));
      sweep(1, 3, 0);
      sweep(0, 0, 1);
      rand_faults(0);
      sweep(1, 3, 0);

      // Mid-sweep reset on a swapped comparator so results are non-zero.
      mode[0] = 2;
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (299) @(negedge clk);
      chk("pre_rst_busy", 32'(busy[0]), 1);
      chk("pre_rst_fcnt_nz", 32'(fcnt[0] != 0), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_reset(0, "async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk_reset(0, "post_rst");
      sweep(0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cmp_bist_ctrl.md
# cmp_bist_ctrl

Hardware stimulus and response checker for the lab 4-bit comparator. It drives all 256 (A, B) operand pairs into the comparator and samples its two outputs after a programmable settle time. Each sample is checked against the team's comparator contract: out1 = (A > B), out2 = (A == B). The block sits next to the comparator instance, replaces the simulation-only fixture on the board, and reports pass/fail, a failure count and the first failing vector.

## Interface

Parameters:
- SETTLE, default 2: wait cycles between driving a vector and sampling the comparator; legal range 0–15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk
- start  in  1  single-cycle run request; sampled only in IDLE or DONE
- a_out  out  4  operand A driven to the comparator
- b_out  out  4  operand B driven to the comparator
- dut_out1  in  1  comparator output out1, expected A > B
- dut_out2  in  1  comparator output out2, expected A == B
- busy  out  1  high while a sweep is in progress
- done  out  1  high from the end of a sweep until the next start or reset
- pass  out  1  valid when done=1; high iff fail_count == 0
- fail_count  out  9  number of mismatching vectors in the last sweep, 0–256
- first_fail_valid  out  1  high once any mismatch has been recorded in the current sweep
- first_fail_a  out  4  A operand of the first mismatching vector
- first_fail_b  out  4  B operand of the first mismatching vector

## Operation

- Internal 8-bit vector index idx: a_out = idx[7:4], b_out = idx[3:0]. The sweep order is 0x00 to 0xFF; B is the fast operand.
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE, with start=1:
  - clear idx, fail_count, first_fail_valid, first_fail_a, first_fail_b and pass
  - go to DRIVE.
- DRIVE: register a_out/b_out from idx. Go to WAIT if SETTLE > 0, else go to CHECK.
- WAIT: a 4-bit settle counter counts SETTLE cycles, then the FSM goes to CHECK.
- CHECK: compare dut_out1/dut_out2 against the expected values computed from a_out/b_out.
  - On mismatch, increment fail_count.
  - On the first mismatch only, capture a_out/b_out into first_fail_a/b and set first_fail_valid.
  - If idx == 0xFF, go to DONE. Otherwise increment idx and go to DRIVE.
- DONE: done=1 and pass = (fail_count == 0). start=1 behaves exactly as start in IDLE (clear, then DRIVE).
- busy = 1 in DRIVE, WAIT and CHECK; otherwise 0.
- start is ignored while busy. No abort input exists; reset is the only abort.
- fail_count is 9 bits and cannot overflow; at most 256 failures are possible.
- idx wrap is never taken: the sweep ends at 0xFF, before any increment past it.

## Timing

- Reset values: state IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, fail_count=0, first_fail_valid=0, first_fail_a=0, first_fail_b=0.
- Reset asserted mid-sweep returns every output to its reset value immediately (asynchronously). No partial result is retained.
- start high in cycle n gives busy=1 from cycle n+1.
- Each vector takes SETTLE+2 cycles: DRIVE, SETTLE×WAIT, CHECK.
- A full sweep takes 256·(SETTLE+2) cycles. With the default SETTLE=2 that is 1024 cycles from the first DRIVE to the DONE entry.
- a_out/b_out are stable from the DRIVE edge through CHECK. The comparator therefore has SETTLE+1 full cycles to settle before sampling.
- Result outputs update on the CHECK edge. done/pass go high on the edge that enters DONE, one cycle after the final CHECK.
- A start received in DONE clears done and pass on the same edge that enters DRIVE.

## Test plan

- Reset then idle: rst_n low, then high; no start for 50 cycles. Required: all outputs at reset values, a_out/b_out=0.
- Good comparator model, SETTLE=2, start pulse. Required:
  - busy high for exactly 1024 cycles
  - done=1, pass=1, fail_count=0, first_fail_valid=0
  - the a_out/b_out sequence visits 0x00 to 0xFF in order.
- Model forces out2=0 only when A=B=0xB:
  - fail_count=1
  - first_fail_valid=1, first_fail_a=4'b1011, first_fail_b=4'b1011
  - pass=0.
- Model swaps out1/out2, i.e. reports out1 = (A == B) and out2 = (A > B):
  - mismatches wherever A > B or A == B
  - fail_count=136 (120+16), first_fail at A=0, B=0.
- SETTLE=0 sweep: 512 busy cycles and the same pass result. A start pulse mid-sweep is ignored, so the cycle count is unchanged.
- Reset asserted at cycle 300 of a sweep: outputs return to reset values immediately. A new start afterwards completes a clean sweep with pass=1.
